// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: host FSM state encoding,
// the funct3 width, the starvation counter width and its default limit.
package dmem_pkg;

   // funct3 carries access size/sign; the arbiter forwards it untouched
   localparam int FUNCT3_W              = 3;

   // Default number of consecutive host denials before a core hold is forced
   localparam int DEFAULT_HOST_MAX_WAIT = 8;

   // Wait counter width; covers the full legal HOST_MAX_WAIT range 1..255
   localparam int WAIT_CNT_W            = 8;

   // Host port FSM: IDLE accepts requests, RESP holds a read response
   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } host_state_t;

   // Saturating increment: stops at lim instead of wrapping
   function automatic logic [WAIT_CNT_W-1:0] sat_inc(
      input logic [WAIT_CNT_W-1:0] value,
      input logic [WAIT_CNT_W-1:0] lim
   );
      logic [WAIT_CNT_W-1:0] result;
      result = (value >= lim) ? lim : value + 1'b1;
      return result;
   endfunction

endpackage

// File: rtl/starve_guard.sv
// Starvation guard for the host port. Counts consecutive cycles in which a
// valid host request is refused while the host FSM is idle, and raises a
// one-cycle core hold once the host has been refused HOST_MAX_WAIT times in
// a row. During that hold the core is blocked, so the host gets the port.
module starve_guard
   import dmem_pkg::*;
#(
   parameter int HOST_MAX_WAIT = DEFAULT_HOST_MAX_WAIT
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_host_valid,
   input  logic                  i_host_ready,
   input  logic                  i_host_idle,
   output logic                  o_core_hold,
   output logic [WAIT_CNT_W-1:0] o_wait_cnt
);

   localparam logic [WAIT_CNT_W-1:0] LP_MAX  = WAIT_CNT_W'(HOST_MAX_WAIT);
   localparam logic [WAIT_CNT_W-1:0] LP_LAST = WAIT_CNT_W'(HOST_MAX_WAIT - 1);

   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic                  r_core_hold;
   logic                  w_denied;

   // A refusal only counts while the FSM could have taken the request;
   // waiting on an outstanding read response is not starvation.
   assign w_denied = i_host_valid & ~i_host_ready & i_host_idle;

   // Track consecutive refusals and fire the one-shot hold on the last allowed one
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wait_cnt  <= '0;
         r_core_hold <= 1'b0;
      end else begin
         if (i_host_ready | ~i_host_valid) begin
            r_wait_cnt <= '0;
         end else if (w_denied) begin
            r_wait_cnt <= sat_inc(r_wait_cnt, LP_MAX);
         end
         // Self-clearing: a hold is never followed directly by another hold
         r_core_hold <= w_denied & (r_wait_cnt == LP_LAST) & ~r_core_hold;
      end
   end

   assign o_core_hold = r_core_hold;
   assign o_wait_cnt  = r_wait_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the barrel pipeline's memory stage (core port)
// and a host/debug loader port. The core has fixed priority with zero-cycle
// latency; the host is served in idle slots and is protected from starvation
// by a forced one-cycle core hold. Host loads return one cycle after grant
// through a registered response that waits for host_rready.
//
// Handshakes: a core access happens in a cycle with core_valid & core_ready;
// the core keeps its request stable until core_ready. A host request is taken
// in a cycle with host_valid & host_ready. A host read response is offered
// with host_rvalid and consumed in the cycle host_rready is high; host_rdata
// keeps its value until the next host load.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_THREADS   = 4,
   parameter int HOST_MAX_WAIT = DEFAULT_HOST_MAX_WAIT,
   localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // core port
   input  logic                     core_valid,
   input  logic                     core_we,
   input  logic [FUNCT3_W-1:0]      core_funct3,
   input  logic [ADDRESS_WIDTH-1:0] core_addr,
   input  logic [DATA_WIDTH-1:0]    core_wdata,
   input  logic [BITS_THREADS-1:0]  core_tid,
   output logic                     core_ready,
   output logic [DATA_WIDTH-1:0]    core_rdata,
   output logic                     core_hold,
   // host port
   input  logic                     host_valid,
   input  logic                     host_we,
   input  logic [FUNCT3_W-1:0]      host_funct3,
   input  logic [ADDRESS_WIDTH-1:0] host_addr,
   input  logic [DATA_WIDTH-1:0]    host_wdata,
   output logic                     host_ready,
   output logic                     host_rvalid,
   output logic [DATA_WIDTH-1:0]    host_rdata,
   input  logic                     host_rready,
   // memory port
   output logic                     mem_we,
   output logic [FUNCT3_W-1:0]      mem_funct3,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic [BITS_THREADS-1:0]  mem_tid,
   // debug visibility of internal state
   output host_state_t              o_dbg_state,
   output logic [WAIT_CNT_W-1:0]    o_dbg_wait_cnt
);

   host_state_t              r_state;
   logic                     r_host_rvalid;
   logic [DATA_WIDTH-1:0]    r_host_rdata;

   logic                     w_core_hold;
   logic                     w_core_grant;
   logic                     w_host_grant;
   logic                     w_host_idle;
   logic [WAIT_CNT_W-1:0]    w_wait_cnt;

   // ------------------------------------------------------------------
   // Grant logic. Both grants are qualified by rst_n so nothing reaches
   // the memory while reset is asserted. The two grants are exclusive:
   // the host only wins when the core is absent or held.
   // ------------------------------------------------------------------
   assign w_host_idle  = (r_state == IDLE);
   assign w_core_grant = rst_n & core_valid & ~w_core_hold;
   assign w_host_grant = rst_n & host_valid & w_host_idle
                       & (~core_valid | w_core_hold);

   assign core_ready   = ~w_core_hold;
   assign core_hold    = w_core_hold;
   assign host_ready   = w_host_grant;

   // Load data is combinational from the memory in the granted cycle
   assign core_rdata   = mem_rdata;

   // ------------------------------------------------------------------
   // Starvation guard
   // ------------------------------------------------------------------
   starve_guard #(
      .HOST_MAX_WAIT (HOST_MAX_WAIT)
   ) u_starve_guard (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_host_valid (host_valid),
      .i_host_ready (w_host_grant),
      .i_host_idle  (w_host_idle),
      .o_core_hold  (w_core_hold),
      .o_wait_cnt   (w_wait_cnt)
   );

   // Route the granted requester onto the memory port; idle slots drive zeros
   always_comb begin
      mem_we     = 1'b0;
      mem_funct3 = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_tid    = '0;
      if (w_core_grant) begin
         mem_we     = core_we;
         mem_funct3 = core_funct3;
         mem_addr   = core_addr;
         mem_wdata  = core_wdata;
         mem_tid    = core_tid;
      end else if (w_host_grant) begin
         mem_we     = host_we;
         mem_funct3 = host_funct3;
         mem_addr   = host_addr;
         mem_wdata  = host_wdata;
      end
   end

   // Host FSM: capture load data at the grant edge and hold it until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_host_rvalid <= 1'b0;
         r_host_rdata  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // Stores complete at the edge and produce no response
               if (w_host_grant & ~host_we) begin
                  r_state       <= RESP;
                  r_host_rvalid <= 1'b1;
                  r_host_rdata  <= mem_rdata;
               end
            end
            RESP: begin
               if (host_rready) begin
                  r_state       <= IDLE;
                  r_host_rvalid <= 1'b0;
               end
            end
            default: begin
               r_state       <= IDLE;
               r_host_rvalid <= 1'b0;
            end
         endcase
      end
   end

   assign host_rvalid    = r_host_rvalid;
   assign host_rdata     = r_host_rdata;
   assign o_dbg_state    = r_state;
   assign o_dbg_wait_cnt = w_wait_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. A word-wide memory array stands in for
// data_memory. A reference model (array memory plus grant rules) predicts
// each cycle's port behaviour and the host read data; a monitor compares.
module tb_dmem_arbiter;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int NT   = 4;
   localparam int TW   = 2;
   localparam int MAXW = 8;
   localparam int MW   = 64;

   // ------------------------------------------------------------------
   // Clock / reset
   // ------------------------------------------------------------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          core_valid, core_we, core_ready, core_hold;
   logic [2:0]    core_funct3;
   logic [AW-1:0] core_addr;
   logic [DW-1:0] core_wdata, core_rdata;
   logic [TW-1:0] core_tid;
   logic          host_valid, host_we, host_ready, host_rvalid, host_rready;
   logic [2:0]    host_funct3;
   logic [AW-1:0] host_addr;
   logic [DW-1:0] host_wdata, host_rdata;
   logic          mem_we;
   logic [2:0]    mem_funct3;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic [TW-1:0] mem_tid;
   logic          dbg_state;
   logic [7:0]    dbg_wait_cnt;

   dmem_arbiter #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .NUM_THREADS   (NT),
      .HOST_MAX_WAIT (MAXW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .core_valid     (core_valid),
      .core_we        (core_we),
      .core_funct3    (core_funct3),
      .core_addr      (core_addr),
      .core_wdata     (core_wdata),
      .core_tid       (core_tid),
      .core_ready     (core_ready),
      .core_rdata     (core_rdata),
      .core_hold      (core_hold),
      .host_valid     (host_valid),
      .host_we        (host_we),
      .host_funct3    (host_funct3),
      .host_addr      (host_addr),
      .host_wdata     (host_wdata),
      .host_ready     (host_ready),
      .host_rvalid    (host_rvalid),
      .host_rdata     (host_rdata),
      .host_rready    (host_rready),
      .mem_we         (mem_we),
      .mem_funct3     (mem_funct3),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_tid        (mem_tid),
      .o_dbg_state    (dbg_state),
      .o_dbg_wait_cnt (dbg_wait_cnt)
   );

   // Memory stand-in: combinational read, synchronous write
   logic [DW-1:0] tb_mem [MW] = '{default: '0};
   assign mem_rdata = tb_mem[mem_addr[7:2]];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr[7:2]] <= mem_wdata;

   // ------------------------------------------------------------------
   // Reference model state and scoreboard queues
   // ------------------------------------------------------------------
   typedef struct {
      logic          core_ready;
      logic          host_ready;
      logic          hold;
      logic          rvalid;
      logic          grant;
      logic          we;
      logic [2:0]    f3;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [TW-1:0] tid;
      logic          chk_crd;
      logic [DW-1:0] crd;
      logic [7:0]    wcnt;
   } exp_t;

   exp_t          cyc_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] ref_mem  [MW] = '{default: '0};
   logic [DW-1:0] ref_save [MW];

   bit m_hold, m_busy, c_acc_last, h_acc_last;
   int m_den;

   // Stimulus currently presented by each requester
   logic          c_v, c_we, h_v, h_we, h_rr;
   logic [2:0]    c_f3, h_f3;
   logic [AW-1:0] c_addr, h_addr;
   logic [DW-1:0] c_wdata, h_wdata;
   logic [TW-1:0] c_tid;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, MW-1)) << 2;
      return a;
   endfunction

   task automatic model_reset();
      m_hold = 0; m_busy = 0; m_den = 0;
      c_acc_last = 1; h_acc_last = 1;
      c_v = 0; h_v = 0; h_rr = 0;
   endtask

   task automatic zero_inputs();
      core_valid = 0; core_we = 0; core_funct3 = 0; core_addr = 0; core_wdata = 0; core_tid = 0;
      host_valid = 0; host_we = 0; host_funct3 = 0; host_addr = 0; host_wdata = 0; host_rready = 0;
   endtask

   // ------------------------------------------------------------------
   // Driver: presents one cycle of stimulus and predicts its outcome
   // ------------------------------------------------------------------
   task automatic drive_cycle();
      exp_t e;
      bit c_acc, h_acc, next_hold;
      @(posedge clk);
      #1;
      core_valid = c_v; core_we = c_we; core_funct3 = c_f3; core_addr = c_addr;
      core_wdata = c_wdata; core_tid = c_tid;
      host_valid = h_v; host_we = h_we; host_funct3 = h_f3; host_addr = h_addr;
      host_wdata = h_wdata; host_rready = h_rr;

      // The core wins unless held; the host needs an idle slot and no pending response
      c_acc = c_v && !m_hold;
      h_acc = h_v && !m_busy && (!c_v || m_hold);

      e.core_ready = !m_hold;
      e.host_ready = h_acc;
      e.hold       = m_hold;
      e.rvalid     = m_busy;
      e.wcnt       = 8'(m_den);
      e.grant      = c_acc || h_acc;
      e.we = 0; e.f3 = 0; e.addr = 0; e.wdata = 0; e.tid = 0;
      e.chk_crd = c_acc && !c_we;
      e.crd     = ref_mem[c_addr[7:2]];
      if (c_acc) begin
         e.we = c_we; e.f3 = c_f3; e.addr = c_addr; e.wdata = c_wdata; e.tid = c_tid;
      end else if (h_acc) begin
         e.we = h_we; e.f3 = h_f3; e.addr = h_addr; e.wdata = h_wdata;
      end
      cyc_q.push_back(e);

      if (h_acc && !h_we) exp_q.push_back(ref_mem[h_addr[7:2]]);
      if (c_acc && c_we)  ref_mem[c_addr[7:2]] = c_wdata;
      if (h_acc && h_we)  ref_mem[h_addr[7:2]] = h_wdata;

      // Host is forced in after MAXW consecutive refusals while it could be served
      next_hold = 0;
      if (h_acc || !h_v) begin
         m_den = 0;
      end else if (!m_busy) begin
         next_hold = (m_den + 1 == MAXW) && !m_hold;
         m_den = (m_den + 1 > MAXW) ? MAXW : m_den + 1;
      end
      if (m_busy && h_rr) m_busy = 0;
      if (h_acc && !h_we) m_busy = 1;
      m_hold     = next_hold;
      c_acc_last = c_acc;
      h_acc_last = h_acc;
   endtask

   // Pick a fresh core request only once the previous one was accepted
   task automatic next_core(input int pct_valid);
      if (c_acc_last || !c_v) begin
         c_v     = ($urandom_range(0, 99) < pct_valid);
         c_we    = 1'($urandom_range(0, 1));
         c_f3    = 3'($urandom_range(0, 7));
         c_addr  = rand_addr();
         c_wdata = $urandom;
         c_tid   = TW'($urandom_range(0, NT-1));
      end
   endtask

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("core_ready",  64'(core_ready),   64'(e.core_ready));
            check("host_ready",  64'(host_ready),   64'(e.host_ready));
            check("core_hold",   64'(core_hold),    64'(e.hold));
            check("host_rvalid", 64'(host_rvalid),  64'(e.rvalid));
            check("wait_cnt",    64'(dbg_wait_cnt), 64'(e.wcnt));
            check("mem_we",      64'(mem_we),       64'(e.we));
            check("mem_addr",    64'(mem_addr),     64'(e.addr));
            check("mem_wdata",   64'(mem_wdata),    64'(e.wdata));
            check("mem_tid",     64'(mem_tid),      64'(e.tid));
            if (e.grant)   check("mem_funct3", 64'(mem_funct3), 64'(e.f3));
            if (e.chk_crd) check("core_rdata", 64'(core_rdata), 64'(e.crd));
         end
         if (rst_n && host_rvalid && host_rready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL host_resp: got unexpected response %0h, required none", host_rdata);
            end else begin
               check("host_rdata", 64'(host_rdata), 64'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin : stimulus
      int  k, holds;
      bit  granted, hold_seen;
      logic cr_at_grant;

      zero_inputs();
      model_reset();
      // Requests present during reset must not reach the memory
      core_valid = 1; core_we = 1; core_addr = 32'h10; host_valid = 1; host_we = 1;
      #12;
      check("rst_mem_we",      64'(mem_we),       64'd0);
      check("rst_mem_addr",    64'(mem_addr),     64'd0);
      check("rst_core_hold",   64'(core_hold),    64'd0);
      check("rst_host_rvalid", 64'(host_rvalid),  64'd0);
      check("rst_host_rdata",  64'(host_rdata),   64'd0);
      check("rst_wait_cnt",    64'(dbg_wait_cnt), 64'd0);
      zero_inputs();
      #10;
      rst_n = 1;

      // Core-only: store then load back with zero latency
      c_v = 1; c_we = 1; c_f3 = 3'b010; c_addr = 32'h10; c_wdata = 32'hDEADBEEF; c_tid = 2;
      h_v = 0; h_we = 0; h_f3 = 0; h_addr = 0; h_wdata = 0; h_rr = 0;
      drive_cycle();
      c_we = 0; c_tid = 1;
      drive_cycle();
      c_v = 0;

      // Host load in an idle slot; response held while rready is low
      h_v = 1; h_we = 0; h_f3 = 3'b010; h_addr = 32'h10;
      drive_cycle();
      h_addr = 32'h20;
      repeat (3) drive_cycle();
      h_rr = 1;
      drive_cycle();
      drive_cycle();
      h_v = 0;
      drive_cycle();
      drive_cycle();

      // Starvation: core busy every cycle, host store waiting
      h_v = 1; h_we = 1; h_f3 = 3'b010; h_addr = 32'h40; h_wdata = $urandom;
      k = 0; holds = 0; granted = 0; cr_at_grant = 1;
      for (int i = 0; i < 30 && !granted; i++) begin
         next_core(100);
         drive_cycle();
         #1;
         k++;
         if (core_hold) holds++;
         if (host_ready) begin
            granted = 1;
            cr_at_grant = core_ready;
         end
      end
      check("starve_grant_cycle", 64'(k), 64'(MAXW + 1));
      check("starve_hold_count",  64'(holds), 64'd1);
      check("starve_core_ready",  64'(cr_at_grant), 64'd0);
      h_v = 0;
      next_core(100);
      drive_cycle();
      c_v = 0;
      c_acc_last = 1;
      drive_cycle();

      // Simultaneous stores to one address: core first, host later
      c_v = 1; c_we = 1; c_addr = 32'h80; c_wdata = 32'h1111_1111; c_f3 = 3'b010; c_tid = 3;
      h_v = 1; h_we = 1; h_addr = 32'h80; h_wdata = 32'h2222_2222;
      drive_cycle();
      c_v = 0;
      drive_cycle();
      h_v = 0;
      drive_cycle();
      @(negedge clk);
      check("simul_final_word", 64'(tb_mem[32]), 64'h2222_2222);

      // Host withdraws in the hold slot
      h_v = 1; h_we = 1; h_addr = 32'h90; h_wdata = $urandom;
      hold_seen = 0;
      for (int i = 0; i < 20 && !hold_seen; i++) begin
         next_core(100);
         if (m_hold) begin
            h_v = 0;
            hold_seen = 1;
         end
         drive_cycle();
         #1;
         if (hold_seen) check("withdraw_mem_we", 64'(mem_we), 64'd0);
      end
      check("withdraw_hold_seen", 64'(hold_seen), 64'd1);
      next_core(100);
      drive_cycle();
      #1;
      check("withdraw_hold_clear", 64'(core_hold),    64'd0);
      check("withdraw_wait_cnt",   64'(dbg_wait_cnt), 64'd0);
      c_v = 0;
      c_acc_last = 1;
      drive_cycle();

      // Reset while a host response is pending
      h_v = 1; h_we = 0; h_addr = 32'h10; h_rr = 0;
      drive_cycle();
      h_v = 0;
      c_v = 1; c_we = 1; c_addr = 32'h30; c_wdata = $urandom;
      ref_save = ref_mem;
      drive_cycle();
      check("pre_reset_rvalid", 64'(host_rvalid), 64'd1);
      #3;
      rst_n = 0;
      cyc_q.delete();
      exp_q.delete();
      #1;
      check("midrst_host_rvalid", 64'(host_rvalid), 64'd0);
      check("midrst_core_hold",   64'(core_hold),   64'd0);
      check("midrst_mem_we",      64'(mem_we),      64'd0);
      ref_mem = ref_save;
      zero_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #7;
      rst_n = 1;
      #1;
      check("post_rst_wait_cnt", 64'(dbg_wait_cnt), 64'd0);
      check("post_rst_rvalid",   64'(host_rvalid),  64'd0);

      // Randomized mixed traffic
      for (int i = 0; i < 600; i++) begin
         next_core(70);
         if (h_acc_last || !h_v) begin
            h_v     = ($urandom_range(0, 99) < 40);
            h_we    = 1'($urandom_range(0, 1));
            h_f3    = 3'($urandom_range(0, 7));
            h_addr  = rand_addr();
            h_wdata = $urandom;
         end else if ($urandom_range(0, 99) < 3) begin
            h_v = 0;
         end
         h_rr = ($urandom_range(0, 99) < 50);
         drive_cycle();
      end

      // Drain outstanding responses
      c_v = 0; h_v = 0; h_rr = 1;
      repeat (4) drive_cycle();
      @(negedge clk);
      #1;
      check("resp_queue_empty", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < MW; i++) check("mem_word", 64'(tb_mem[i]), 64'(ref_mem[i]));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported data memory between two requesters:
  - the barrel pipeline's execute/memory boundary (core port, tagged with thread id);
  - a host/debug loader port, used for program data preload and for inspection while the core runs.
- The core has fixed priority. The host is served in idle slots.
- A bounded-wait counter forces a one-cycle core hold so the host cannot starve.
- Sits between the memory stage and data_memory. Drives the memory's write enable, funct3, address and write data.

Parameters:
- ADDRESS_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width.
- NUM_THREADS, 4, barrel thread count; BITS_THREADS = $clog2(NUM_THREADS).
- HOST_MAX_WAIT, 8, maximum consecutive cycles a valid host request may be denied before a core hold is forced (legal range 1..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- core_valid  in  1  core memory access request this cycle (load or store).
- core_we  in  1  1 = store, 0 = load.
- core_funct3  in  3  access size/sign, passed to memory.
- core_addr  in  ADDRESS_WIDTH  byte address.
- core_wdata  in  DATA_WIDTH  store data.
- core_tid  in  BITS_THREADS  issuing thread.
- core_ready  out  1  core access accepted this cycle.
- core_rdata  out  DATA_WIDTH  load data, valid when core_valid & core_ready & !core_we.
- core_hold  out  1  registered; tells the thread scheduler the next slot must not issue a memory op.
- host_valid  in  1  host request.
- host_we  in  1  host store.
- host_funct3  in  3  host access size.
- host_addr  in  ADDRESS_WIDTH  host address.
- host_wdata  in  DATA_WIDTH  host store data.
- host_ready  out  1  host request accepted this cycle.
- host_rvalid  out  1  host read response valid.
- host_rdata  out  DATA_WIDTH  host read data.
- host_rready  in  1  host consumes response.
- mem_we  out  1  memory write enable.
- mem_funct3  out  3  memory funct3.
- mem_addr  out  ADDRESS_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data (combinational read, synchronous write).
- mem_tid  out  BITS_THREADS  core_tid when the core owns the port, else 0.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, wait_cnt = 0, core_hold = 0;
  - host_rvalid = 0, host_rdata = 0;
  - all mem_* outputs are 0 while in reset.
- Grant logic (combinational, per cycle):
  - core_ready = !core_hold.
  - host_ready = host_valid & (state == IDLE) & (!core_valid | core_hold).
  - core_hold = 1 blocks core_valid; the core must hold its request stable until core_ready.
- Port mux:
  - core_valid & core_ready: mem_* from core, mem_tid = core_tid.
  - else host_ready: mem_* from host.
  - else mem_we = 0, address/data = 0.
  - mem_we is never 1 unless a request is granted that cycle.
- Core latency: 0 cycles. core_rdata = mem_rdata in the granted cycle.
- Host FSM:
  - IDLE → RESP on a granted host load. host_rdata <= mem_rdata and host_rvalid <= 1 at that edge (latency 1).
  - A granted host store completes at the edge and stays in IDLE; no response is generated.
  - RESP → IDLE when host_rready = 1. host_rvalid clears at that edge.
  - In RESP, host_ready = 0.
  - host_rdata holds its value until the next host load.
- Starvation counter:
  - wait_cnt increments when host_valid & !host_ready & (state == IDLE).
  - wait_cnt clears when a host request is granted or host_valid = 0.
  - When wait_cnt == HOST_MAX_WAIT-1 and the host is denied again, core_hold <= 1 for exactly one cycle.
  - The host is therefore granted within HOST_MAX_WAIT+1 cycles of first assertion.
  - core_hold is self-clearing; it never stays high two consecutive cycles.
  - wait_cnt saturates and never wraps.
- No host request during hold: core_hold still deasserts after one cycle. That slot is lost, and wait_cnt clears because host_valid = 0.
- Simultaneous core and host requests, no hold: the core wins. The host waits with no side effects.
- Reset mid-RESP: the response is dropped and host_rvalid = 0 immediately.
- Address and width checking is the memory's responsibility. The arbiter passes funct3 through unchanged.

Decomposition:
- Shared package dmem_pkg:
  - state encoding (IDLE = 1'b0, RESP = 1'b1);
  - funct3 width constant;
  - default HOST_MAX_WAIT.
- One natural sub-module, starve_guard: wait_cnt plus one-shot core_hold generation, parameterised by HOST_MAX_WAIT.
- The mux and FSM remain in dmem_arbiter.

Test Plan:
- Reset: rst_n low mid-operation with host_rvalid = 1 → host_rvalid, core_hold and mem_we are 0 within the same cycle. wait_cnt is 0 after release.
- Core-only traffic: store 0xDEADBEEF to 0x10, funct3 = 010, tid = 2 → core_ready = 1, mem_we = 1, mem_tid = 2. A load from 0x10 the next cycle returns core_rdata = 0xDEADBEEF in the same cycle.
- Host in idle slot: core_valid = 0, host load from 0x10 → host_ready = 1. The next cycle host_rvalid = 1, host_rdata = 0xDEADBEEF. With host_rready low for 3 cycles, rvalid stays held and host_ready = 0.
- Starvation: core_valid = 1 every cycle, host_valid = 1, HOST_MAX_WAIT = 8 → core_hold is high for exactly one cycle after 8 denials. The host is granted in that cycle, with core_ready = 0 there. No core access is lost and the core request is held stable.
- Simultaneous: core store and host store to the same address in the same cycle → only the core write reaches memory. The host store lands in a later slot, and the final memory value is the host data.
- Host withdraws during hold: host_valid drops the cycle core_hold rises → mem_we = 0 in the hold slot, core_hold clears next cycle, wait_cnt = 0.
